// File: rtl/vedic_32x32_seq.sv
// vedic_32x32_seq: sequential 32x32 -> 64-bit multiplier built around a
// single 16x16 Vedic (Urdhva-Tiryagbhyam) core. The core is reused over
// four cycles, one per 16x16 partial product, and the results are summed
// into a 64-bit accumulator.
// Optional feature: define VEDIC32_SIGNED_EN to add the in_signed port,
// which selects two's-complement operands (sign-magnitude internally).

// Recursive Vedic block: a DATA_W x DATA_W multiplier built from four
// half-width blocks, bottoming out in the 2x2 crosswise cell.
module vedic_block #(
   parameter int DATA_W = 2
) (
   input  logic [DATA_W-1:0]   a,
   input  logic [DATA_W-1:0]   b,
   output logic [2*DATA_W-1:0] p
);
   generate
      if (DATA_W == 2) begin : g_base
         logic c;
         assign p[0] = a[0] & b[0];
         assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
         assign c    = (a[1] & b[0]) & (a[0] & b[1]);
         assign p[2] = (a[1] & b[1]) ^ c;
         assign p[3] = (a[1] & b[1]) & c;
      end else begin : g_split
         localparam int H = DATA_W / 2;
         logic [DATA_W-1:0] q_ll;
         logic [DATA_W-1:0] q_hl;
         logic [DATA_W-1:0] q_lh;
         logic [DATA_W-1:0] q_hh;
         logic [DATA_W:0]   mid;

         vedic_block #(.DATA_W(H)) u_ll (.a(a[H-1:0]),      .b(b[H-1:0]),      .p(q_ll));
         vedic_block #(.DATA_W(H)) u_hl (.a(a[DATA_W-1:H]), .b(b[H-1:0]),      .p(q_hl));
         vedic_block #(.DATA_W(H)) u_lh (.a(a[H-1:0]),      .b(b[DATA_W-1:H]), .p(q_lh));
         vedic_block #(.DATA_W(H)) u_hh (.a(a[DATA_W-1:H]), .b(b[DATA_W-1:H]), .p(q_hh));

         // Crosswise terms share weight 2^H; vertical terms concatenate.
         assign mid = {1'b0, q_hl} + {1'b0, q_lh};
         assign p   = {q_hh, q_ll} + {{(H-1){1'b0}}, mid, {H{1'b0}}};
      end
   endgenerate
endmodule

// The existing 16x16 Vedic multiplier (32-bit result).
module vedic_16x16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [31:0] p
);
   vedic_block #(.DATA_W(16)) u_core (.a(a), .b(b), .p(p));
endmodule

module vedic_32x32_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
`ifdef VEDIC32_SIGNED_EN
   input  logic        in_signed,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] p,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  step_q,  step_d;
   logic [63:0] acc_q,   acc_d;
   logic [31:0] a_q,     a_d;
   logic [31:0] b_q,     b_d;

   logic [15:0] pp_a;
   logic [15:0] pp_b;
   logic [31:0] pp;
   logic [63:0] pp_ext;
   logic [63:0] acc_sum;

`ifdef VEDIC32_SIGNED_EN
   logic        sign_q, sign_d;

   // Magnitude of a two's-complement word; 0x80000000 maps to itself,
   // which is the correct unsigned magnitude 2^31.
   function automatic logic [31:0] mag32(input logic signed [31:0] v, input logic is_signed);
      logic [31:0] r;
      r = v;
      if (is_signed && v[31])
         r = ~v + 32'd1;
      return r;
   endfunction

   // Two's-complement negation of the final 64-bit product.
   function automatic logic [63:0] neg64(input logic signed [63:0] v);
      return ~v + 64'd1;
   endfunction
`endif

   // Choose the operand halves for the partial product of the current step.
   always_comb begin
      pp_a = a_q[15:0];
      pp_b = b_q[15:0];
      case (step_q)
         2'd0: begin pp_a = a_q[15:0];  pp_b = b_q[15:0];  end
         2'd1: begin pp_a = a_q[31:16]; pp_b = b_q[15:0];  end
         2'd2: begin pp_a = a_q[15:0];  pp_b = b_q[31:16]; end
         default: begin pp_a = a_q[31:16]; pp_b = b_q[31:16]; end
      endcase
   end

   vedic_16x16 u_mul (.a(pp_a), .b(pp_b), .p(pp));

   // Align the partial product to its weight and add it to the accumulator.
   always_comb begin
      pp_ext = {32'd0, pp};
      case (step_q)
         2'd0:    pp_ext = {32'd0, pp};
         2'd1,
         2'd2:    pp_ext = {16'd0, pp, 16'd0};
         default: pp_ext = {pp, 32'd0};
      endcase
      acc_sum = acc_q + pp_ext;
   end

   // Next-state logic: accept in IDLE, accumulate four steps in MUL,
   // hold the product in DONE until the consumer takes it.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      acc_d   = acc_q;
      a_d     = a_q;
      b_d     = b_q;
`ifdef VEDIC32_SIGNED_EN
      sign_d  = sign_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
`ifdef VEDIC32_SIGNED_EN
               a_d    = mag32(a, in_signed);
               b_d    = mag32(b, in_signed);
               sign_d = in_signed & (a[31] ^ b[31]);
`else
               a_d    = a;
               b_d    = b;
`endif
               acc_d   = 64'd0;
               step_d  = 2'd0;
               state_d = MUL;
            end
         end
         MUL: begin
            acc_d  = acc_sum;
            step_d = step_q + 2'd1;
            if (step_q == 2'd3) begin
               state_d = DONE;
`ifdef VEDIC32_SIGNED_EN
               if (sign_q)
                  acc_d = neg64(acc_sum);
`endif
            end
         end
         DONE: begin
            if (out_ready)
               state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, step counter, operands and accumulator; reset aborts any operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         step_q  <= 2'd0;
         acc_q   <= 64'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
`ifdef VEDIC32_SIGNED_EN
         sign_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         b_q     <= b_d;
`ifdef VEDIC32_SIGNED_EN
         sign_q  <= sign_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == MUL);
   assign out_valid = (state_q == DONE);
   assign p         = acc_q;

endmodule

// File: tb/tb_vedic_32x32_seq.sv
// Bench for vedic_32x32_seq: directed vector table, hand-written sequences
// for hold/abort corners, and a random back-to-back stream.
module tb_vedic_32x32_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] p;
   logic        busy;
`ifdef VEDIC32_SIGNED_EN
   logic        in_signed;
`endif

   int n_vec  = 0;
   int n_fail = 0;

   vedic_32x32_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
`ifdef VEDIC32_SIGNED_EN
      .in_signed (in_signed),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] ta, input logic [31:0] tb_v, input logic sgn);
      a = ta;
      b = tb_v;
      in_valid = 1'b1;
`ifdef VEDIC32_SIGNED_EN
      in_signed = sgn;
`else
      if (sgn) $display("note: signed operand request ignored in unsigned build");
`endif
   endtask

   // Called right after the acceptance edge; scrambles operands, measures
   // latency and busy cycles, holds DONE for 'hold' cycles, then hands off.
   task automatic finish_op(input string name, input logic [63:0] exp, input int hold, input logic chk_busy);
      int edges;
      int busy_cnt;
      edges = 0;
      busy_cnt = 0;
      #1;
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      while (!out_valid && edges < 20) begin
         busy_cnt += int'(busy);
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      check({name, "_latency"}, 64'(edges), 64'd4);
      if (chk_busy) check({name, "_busy_cycles"}, 64'(busy_cnt), 64'd4);
      check({name, "_p"}, p, exp);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         a = 32'h0000_0002;
         b = 32'h0000_0003;
         @(negedge clk);
         check({name, "_hold_p"}, p, exp);
         check({name, "_hold_valid"}, 64'(out_valid), 64'd1);
         check({name, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({name, "_idle_after"}, 64'(in_ready), 64'd1);
   endtask

   task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic sgn, input logic [63:0] exp, input int hold);
      int g;
      g = 0;
      @(negedge clk);
      while (!in_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      check({name, "_in_ready"}, 64'(in_ready), 64'd1);
      drive(ta, tb_v, sgn);
      @(posedge clk);
      finish_op(name, exp, hold, 1'b0);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      int          ov_seen;

      vecs[0]  = '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F};
      vecs[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
      vecs[2]  = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
      vecs[3]  = '{32'h0000_0000, 32'hDEAD_BEEF, 64'h0000_0000_0000_0000};
      vecs[4]  = '{32'h0000_0001, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
      vecs[5]  = '{32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001};
      vecs[6]  = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
      vecs[7]  = '{32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE};
      vecs[8]  = '{32'h0001_0000, 32'h0000_FFFF, 64'h0000_0000_FFFF_0000};
      vecs[9]  = '{32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780};
      vecs[10] = '{32'hFFFF_0000, 32'hFFFF_0000, 64'hFFFE_0001_0000_0000};
      vecs[11] = '{32'h0000_FFFF, 32'hFFFF_0000, 64'h0000_FFFE_0001_0000};

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = 32'd0;
      b = 32'd0;
`ifdef VEDIC32_SIGNED_EN
      in_signed = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_p", p, 64'd0);

      // First acceptance on the first rising edge after reset release.
      rst = 1'b0;
      drive(32'd3, 32'd5, 1'b0);
      @(posedge clk);
      finish_op("first_3x5", 64'h0000_0000_0000_000F, 0, 1'b1);

      for (int i = 0; i < 12; i++)
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 1'b0, vecs[i].exp, 0);

      // Consumer stalls for three cycles in DONE; a second request is ignored.
      run_op("hold", 32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000, 3);

      // Reset during the step2 cycle aborts the operation.
      @(negedge clk);
      drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_p", p, 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      ov_seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         ov_seen += int'(out_valid);
      end
      check("abort_no_valid", 64'(ov_seen), 64'd0);
      run_op("after_abort_7x9", 32'd7, 32'd9, 1'b0, 64'd63, 0);

`ifdef VEDIC32_SIGNED_EN
      run_op("signed_m2x3", 32'hFFFF_FFFE, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 0);
      run_op("signed_min_sq", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0);
      run_op("unsigned_in_signed_build", 32'hFFFF_FFFE, 32'd3, 1'b0, 64'h0000_0002_FFFF_FFFA, 0);
`endif

      // Random back-to-back stream with random consumer stalls.
      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rb = $urandom;
         run_op("stream", ra, rb, 1'b0, {32'd0, ra} * {32'd0, rb}, int'($urandom_range(0, 2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
